// File: rtl/home_event_scheduler.sv
// Home-monitor event scheduler: detects lights/plugs/temperature changes and issues one report
// word at a time (round-robin between sources) on a valid/ready link to the recorder.
module home_event_scheduler #(
    parameter int TEMP_DELTA = 2,
    parameter int TEMP_RESET = 20,
    parameter int HEARTBEAT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lights,
    input  logic       plugs,
    input  logic [4:0] temperature,
    input  logic       data_ready,
    output logic       data_valid,
    output logic [5:0] data,
    output logic       lights_old,
    output logic       plugs_old,
    output logic [4:0] temperature_old
);

    localparam bit HB_EN  = (HEARTBEAT > 0);
    localparam int HB_MAX = (HEARTBEAT > 0) ? HEARTBEAT - 1 : 0;
    localparam int HB_W   = (HEARTBEAT > 2) ? $clog2(HEARTBEAT) : 1;

    typedef enum logic [1:0] {SRC_L, SRC_P, SRC_T} src_t;
    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_next;
    src_t            ptr, gsel;
    logic            grant;
    logic            s_l, s_p;
    logic [4:0]      s_t;
    logic [HB_W-1:0] hb_cnt;
    logic            hb_flag;
    logic [5:0]      t_delta;
    logic            pend_l, pend_p, pend_t;
    logic [5:0]      word;

    // Magnitude of a - b, computed one bit wider so the subtraction cannot wrap.
    function automatic logic [5:0] abs_diff(input logic [4:0] a, input logic [4:0] b);
        logic signed [5:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[5] ? $unsigned(-d) : $unsigned(d);
    endfunction

    assign t_delta = abs_diff(s_t, temperature_old);
    assign pend_l  = (s_l != lights_old);
    assign pend_p  = (s_p != plugs_old);
    assign pend_t  = (t_delta >= 6'(TEMP_DELTA)) || hb_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        gsel       = ptr;
        case (state)
            IDLE: begin
                if (pend_l || pend_p || pend_t) begin
                    grant      = 1'b1;
                    state_next = WAIT;
                    // Search starts just after the last granted source.
                    case (ptr)
                        SRC_L:   gsel = pend_p ? SRC_P : (pend_t ? SRC_T : SRC_L);
                        SRC_P:   gsel = pend_t ? SRC_T : (pend_l ? SRC_L : SRC_P);
                        default: gsel = pend_l ? SRC_L : (pend_p ? SRC_P : SRC_T);
                    endcase
                end
            end
            WAIT: begin
                if (data_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (gsel)
            SRC_L:   word = {5'b00000, s_l};
            SRC_P:   word = {2'b01, 3'b000, s_p};
            default: word = {1'b1, s_t};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_l             <= 1'b0;
            s_p             <= 1'b0;
            s_t             <= 5'(TEMP_RESET);
            lights_old      <= 1'b0;
            plugs_old       <= 1'b0;
            temperature_old <= 5'(TEMP_RESET);
            data            <= '0;
            data_valid      <= 1'b0;
            ptr             <= SRC_T;
            hb_cnt          <= '0;
            hb_flag         <= 1'b0;
        end else begin
            s_l <= lights;
            s_p <= plugs;
            s_t <= temperature;
            if (grant) begin
                data       <= word;
                data_valid <= 1'b1;
                ptr        <= gsel;
                case (gsel)
                    SRC_L:   lights_old      <= s_l;
                    SRC_P:   plugs_old       <= s_p;
                    default: temperature_old <= s_t;
                endcase
            end else if (state == WAIT && data_ready) begin
                data_valid <= 1'b0;
            end
            // Heartbeat restarts on any temperature grant, whatever its cause.
            if (HB_EN) begin
                if (grant && gsel == SRC_T) begin
                    hb_cnt  <= '0;
                    hb_flag <= 1'b0;
                end else if (hb_cnt == HB_W'(HB_MAX)) begin
                    hb_flag <= 1'b1;
                end else begin
                    hb_cnt <= hb_cnt + HB_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/home_event_scheduler.md
Name: home_event_scheduler

Overview:
- Sequences the home-monitor recorder: watches the lights, plugs and temperature inputs and detects reportable changes.
- Arbitrates between the three event sources round-robin and issues one 6-bit report word at a time on a valid/ready interface into the data recorder.
- Keeps the last-reported value of each source, exported as the *_old outputs.
- Adds temperature hysteresis and a periodic temperature heartbeat.

Parameters:
- TEMP_DELTA, 2, minimum |temperature - temperature_old| that makes temperature pending; legal range 1..31.
- TEMP_RESET, 20, reset value of temperature_old (5-bit).
- HEARTBEAT, 64, cycles since the last accepted temperature word after which a temperature report is forced; 0 disables.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous, active-low; every flop clears while rst=0.
- lights  in  1  lights on/off.
- plugs  in  1  plugs on/off.
- temperature  in  5  temperature, unsigned degrees, 0..31.
- data_ready  in  1  recorder can accept a word.
- data_valid  out  1  data holds a report word.
- data  out  6  report word.
- lights_old  out  1  last lights value reported.
- plugs_old  out  1  last plugs value reported.
- temperature_old  out  5  last temperature value reported.

Behaviour:
- Reset values:
  - data_valid=0, data=0, lights_old=0, plugs_old=0, temperature_old=TEMP_RESET.
  - Sample registers reset to the same values as the *_old outputs.
  - Heartbeat counter=0, hb_flag=0, state=IDLE.
  - Round-robin pointer = T, so L has first priority.
- Input sampling: lights, plugs and temperature are registered every cycle (s_l, s_p, s_t). All decisions use the sampled values.
- Pending conditions (combinational, self-coalescing):
  - pend_L = (s_l != lights_old).
  - pend_P = (s_p != plugs_old).
  - pend_T = (|s_t - temperature_old| >= TEMP_DELTA) or hb_flag. Compute the difference 6-bit, sign-safe.
  - A change that reverts before grant produces no word.
- Word format:
  - L: data = {2'b00, 3'b000, s_l}.
  - P: data = {2'b01, 3'b000, s_p}.
  - T: data = {1'b1, s_t}.
- State machine, IDLE:
  - If any pending, grant the first pending source in circular order starting after the pointer (order L, P, T).
  - At that edge: load data, set data_valid=1, update the granted *_old to its sampled value, set the pointer to the granted source, go to WAIT.
  - If nothing is pending, data_valid=0 and data holds its last value.
- State machine, WAIT:
  - data and data_valid are held stable until data_ready=1.
  - On the edge with data_valid & data_ready: data_valid=0 next cycle, go to IDLE.
  - Max throughput is one word per 2 cycles. data_ready while idle is ignored.
- Latency: an input change at edge N is sampled at N+1 and granted at N+2, so data_valid is high after edge N+2 when idle.
- Heartbeat (HEARTBEAT>0):
  - Counter increments every cycle and is cleared on the edge a T word is granted (delta or heartbeat cause).
  - When counter reaches HEARTBEAT-1, hb_flag=1 and the counter saturates.
  - hb_flag clears on T grant.
  - A heartbeat T word carries the current s_t even if unchanged.
- Simultaneous events:
  - Changes arriving during WAIT stay pending and are served afterwards in round-robin order.
  - A granted source drops to lowest priority, so no source can starve another.
- Reset mid-operation: an asserted rst aborts WAIT immediately. data_valid drops asynchronously and all state returns to reset values; a pending word is discarded.

Test Plan:
- Reset release with lights=0, plugs=0, temperature=20, data_ready=1 -> data_valid stays 0 for 60 cycles; *_old = 0/0/20.
- Idle, lights 0->1 at edge N, data_ready=1:
  - data_valid=1 with data=6'b000001 after N+2, dropping after N+3.
  - lights_old=1 from N+2.
- Same-cycle lights=1, plugs=1, temperature=31 from reset, data_ready=1:
  - Words 6'b000001, 6'b010001, 6'b111111 in that order, 2 cycles apart.
  - *_old end at 1/1/31.
- Hysteresis, temperature_old=20, TEMP_DELTA=2:
  - temperature=21 gives no word.
  - temperature=22 gives data=6'b110110.
  - temperature back to 21 gives no word.
- Backpressure, data_ready=0 while L word is valid:
  - data held at 6'b000001 for 10 cycles while plugs toggles 0->1.
  - After ready: P word 6'b010001 follows.
  - A plugs toggle 0->1->0 inside WAIT yields no P word.
- Heartbeat with HEARTBEAT=8, inputs static at temperature=20 -> T word 6'b110100 every ~9 cycles with ready=1; rst pulled low mid-WAIT -> data_valid=0 immediately, temperature_old=20.
